// File: rtl/axi_lite_to_axi_ot.sv
// AXI4-Lite slave to single-beat AXI4 master bridge with a fixed AxID, outstanding-transaction
// limits per direction, an optional AW/AR register cut and status outputs.
package axi_lite_to_axi_ot_pkg;
  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  prot;
  } lite_ax_t;
  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
  } lite_w_t;
  typedef struct packed {
    logic [1:0] resp;
  } lite_b_t;
  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } lite_r_t;
  typedef struct packed {
    lite_ax_t aw;
    logic     aw_valid;
    lite_w_t  w;
    logic     w_valid;
    logic     b_ready;
    lite_ax_t ar;
    logic     ar_valid;
    logic     r_ready;
  } lite_req_t;
  typedef struct packed {
    logic    aw_ready;
    logic    w_ready;
    lite_b_t b;
    logic    b_valid;
    logic    ar_ready;
    lite_r_t r;
    logic    r_valid;
  } lite_resp_t;
  typedef struct packed {
    logic [7:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        lock;
    logic [3:0]  cache;
    logic [2:0]  prot;
    logic [3:0]  qos;
    logic [3:0]  region;
    logic [5:0]  atop;
    logic [0:0]  user;
  } axi_aw_t;
  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
    logic [0:0]  user;
  } axi_w_t;
  typedef struct packed {
    logic [7:0] id;
    logic [1:0] resp;
    logic [0:0] user;
  } axi_b_t;
  typedef struct packed {
    logic [7:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        lock;
    logic [3:0]  cache;
    logic [2:0]  prot;
    logic [3:0]  qos;
    logic [3:0]  region;
    logic [0:0]  user;
  } axi_ar_t;
  typedef struct packed {
    logic [7:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [0:0]  user;
  } axi_r_t;
  typedef struct packed {
    axi_aw_t aw;
    logic    aw_valid;
    axi_w_t  w;
    logic    w_valid;
    logic    b_ready;
    axi_ar_t ar;
    logic    ar_valid;
    logic    r_ready;
  } axi_req_t;
  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    axi_b_t  b;
    logic    r_valid;
    axi_r_t  r;
  } axi_resp_t;
endpackage

module axi_lite_to_axi_ot #(
  parameter int unsigned AxiDataWidth = 32,
  parameter int unsigned AxiIdWidth   = 8,
  parameter int unsigned AxiId        = 0,
  parameter int unsigned MaxWrTxns    = 4,
  parameter int unsigned MaxRdTxns    = 4,
  parameter bit          CutAx        = 1'b1,
  parameter type lite_req_t   = axi_lite_to_axi_ot_pkg::lite_req_t,
  parameter type lite_resp_t  = axi_lite_to_axi_ot_pkg::lite_resp_t,
  parameter type axi_aw_t     = axi_lite_to_axi_ot_pkg::axi_aw_t,
  parameter type axi_ar_t     = axi_lite_to_axi_ot_pkg::axi_ar_t,
  parameter type axi_req_t    = axi_lite_to_axi_ot_pkg::axi_req_t,
  parameter type axi_resp_t   = axi_lite_to_axi_ot_pkg::axi_resp_t
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  lite_req_t                      slv_req_i,
  output lite_resp_t                     slv_resp_o,
  input  logic [3:0]                     slv_aw_cache_i,
  input  logic [3:0]                     slv_ar_cache_i,
  output axi_req_t                       mst_req_o,
  input  axi_resp_t                      mst_resp_i,
  output logic [$clog2(MaxWrTxns+1)-1:0] wr_cnt_o,
  output logic [$clog2(MaxRdTxns+1)-1:0] rd_cnt_o,
  output logic                           busy_o
);

  localparam int unsigned WrCntW = $clog2(MaxWrTxns + 1);
  localparam int unsigned RdCntW = $clog2(MaxRdTxns + 1);
  localparam logic [WrCntW-1:0]     WrMax   = WrCntW'(MaxWrTxns);
  localparam logic [RdCntW-1:0]     RdMax   = RdCntW'(MaxRdTxns);
  localparam logic [AxiIdWidth-1:0] IdVal   = AxiIdWidth'(AxiId);
  localparam logic [2:0]            AxSize  = 3'($clog2(AxiDataWidth / 8));
  localparam logic [1:0]            BurstIncr = 2'b01;

  logic [WrCntW-1:0] wr_cnt_q;
  logic [RdCntW-1:0] rd_cnt_q;
  logic    wr_ok, rd_ok;
  logic    slv_aw_ready, slv_ar_ready;
  logic    aw_hs, ar_hs, b_hs, r_hs;
  logic    aw_full, ar_full;
  logic    mst_aw_valid, mst_ar_valid;
  axi_aw_t aw_new, aw_out;
  axi_ar_t ar_new, ar_out;

  assign wr_ok = wr_cnt_q < WrMax;
  assign rd_ok = rd_cnt_q < RdMax;
  assign aw_hs = slv_req_i.aw_valid & slv_aw_ready;
  assign ar_hs = slv_req_i.ar_valid & slv_ar_ready;
  assign b_hs  = mst_resp_i.b_valid & slv_req_i.b_ready;
  assign r_hs  = mst_resp_i.r_valid & slv_req_i.r_ready;

  always_comb begin
    aw_new       = '0;
    aw_new.id    = IdVal;
    aw_new.addr  = slv_req_i.aw.addr;
    aw_new.size  = AxSize;
    aw_new.burst = BurstIncr;
    aw_new.prot  = slv_req_i.aw.prot;
    aw_new.cache = slv_aw_cache_i;
    ar_new       = '0;
    ar_new.id    = IdVal;
    ar_new.addr  = slv_req_i.ar.addr;
    ar_new.size  = AxSize;
    ar_new.burst = BurstIncr;
    ar_new.prot  = slv_req_i.ar.prot;
    ar_new.cache = slv_ar_cache_i;
  end

  if (CutAx) begin : g_cut
    logic    aw_full_q, ar_full_q;
    axi_aw_t aw_q;
    axi_ar_t ar_q;

    // A full register still accepts when it drains in the same cycle: no bubble.
    assign slv_aw_ready = !rst_i && wr_ok && (!aw_full_q || mst_resp_i.aw_ready);
    assign slv_ar_ready = !rst_i && rd_ok && (!ar_full_q || mst_resp_i.ar_ready);

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        aw_full_q <= 1'b0;
        ar_full_q <= 1'b0;
        aw_q      <= '0;
        ar_q      <= '0;
      end else begin
        if (aw_hs) begin
          aw_full_q <= 1'b1;
          aw_q      <= aw_new;
        end else if (mst_resp_i.aw_ready) begin
          aw_full_q <= 1'b0;
        end
        if (ar_hs) begin
          ar_full_q <= 1'b1;
          ar_q      <= ar_new;
        end else if (mst_resp_i.ar_ready) begin
          ar_full_q <= 1'b0;
        end
      end
    end

    assign aw_full      = aw_full_q;
    assign ar_full      = ar_full_q;
    assign mst_aw_valid = aw_full_q;
    assign mst_ar_valid = ar_full_q;
    assign aw_out       = aw_q;
    assign ar_out       = ar_q;
  end else begin : g_comb
    assign slv_aw_ready = !rst_i && wr_ok && mst_resp_i.aw_ready;
    assign slv_ar_ready = !rst_i && rd_ok && mst_resp_i.ar_ready;
    assign aw_full      = 1'b0;
    assign ar_full      = 1'b0;
    assign mst_aw_valid = !rst_i && wr_ok && slv_req_i.aw_valid;
    assign mst_ar_valid = !rst_i && rd_ok && slv_req_i.ar_valid;
    assign aw_out       = aw_new;
    assign ar_out       = ar_new;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      if (aw_hs && !b_hs) begin
        wr_cnt_q <= wr_cnt_q + WrCntW'(1);
      end else if (!aw_hs && b_hs && wr_cnt_q != '0) begin
        wr_cnt_q <= wr_cnt_q - WrCntW'(1);
      end
      if (ar_hs && !r_hs) begin
        rd_cnt_q <= rd_cnt_q + RdCntW'(1);
      end else if (!ar_hs && r_hs && rd_cnt_q != '0) begin
        rd_cnt_q <= rd_cnt_q - RdCntW'(1);
      end
    end
  end

  always_comb begin
    mst_req_o          = '0;
    mst_req_o.aw       = aw_out;
    mst_req_o.aw_valid = mst_aw_valid;
    mst_req_o.w.data   = slv_req_i.w.data;
    mst_req_o.w.strb   = slv_req_i.w.strb;
    mst_req_o.w.last   = 1'b1;
    mst_req_o.w_valid  = slv_req_i.w_valid;
    mst_req_o.b_ready  = slv_req_i.b_ready;
    mst_req_o.ar       = ar_out;
    mst_req_o.ar_valid = mst_ar_valid;
    mst_req_o.r_ready  = slv_req_i.r_ready;

    slv_resp_o          = '0;
    slv_resp_o.aw_ready = slv_aw_ready;
    slv_resp_o.w_ready  = mst_resp_i.w_ready;
    slv_resp_o.b.resp   = mst_resp_i.b.resp;
    slv_resp_o.b_valid  = mst_resp_i.b_valid;
    slv_resp_o.ar_ready = slv_ar_ready;
    slv_resp_o.r.data   = mst_resp_i.r.data;
    slv_resp_o.r.resp   = mst_resp_i.r.resp;
    slv_resp_o.r_valid  = mst_resp_i.r_valid;
  end

  assign wr_cnt_o = wr_cnt_q;
  assign rd_cnt_o = rd_cnt_q;
  assign busy_o   = (wr_cnt_q != '0) || (rd_cnt_q != '0) || aw_full || ar_full;

`ifndef SYNTHESIS
  // A response with nothing outstanding means the downstream invented a transaction.
  assert property (@(posedge clk_i) disable iff (rst_i) !(b_hs && wr_cnt_q == '0))
    else $error("B handshake with no outstanding write");
  assert property (@(posedge clk_i) disable iff (rst_i) !(r_hs && rd_cnt_q == '0))
    else $error("R handshake with no outstanding read");
`endif

endmodule
